// File: rtl/hf_compression_table.sv
// Table-driven serial Huffman encoder.
// Symbols are accepted over a valid/ready handshake and looked up in a loadable
// code table. Each variable-length code is then shifted out MSB first, one bit
// per clock. With EN low at accept time, the raw symbol is sent instead.
// Optional build macro HF_LEN_PREFIX_EN: in compress mode, send the LEN_W-bit
// code length, MSB first, ahead of the code bits.
module hf_compression_table #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 6
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               EN,
  input  logic [SYM_W-1:0]   sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]   tbl_len,
  output logic               hf_out,
  output logic               hf_valid,
  output logic               hf_last,
  output logic               code_err,
  output logic               busy
);

  localparam int                 TBL_N     = 1 << SYM_W;
  localparam int                 BYP_SH    = MAX_LEN - SYM_W;
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   ONE_L     = LEN_W'(1);

`ifdef HF_LEN_PREFIX_EN
  typedef enum logic [1:0] {IDLE, LOOKUP, PREFIX, SHIFT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOOKUP, SHIFT} state_t;
`endif

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] tbl_code_q [TBL_N];
  logic [LEN_W-1:0]   tbl_len_q  [TBL_N];

  logic [SYM_W-1:0]   sym_q;
  logic               en_q;
  logic [MAX_LEN-1:0] shreg;
  logic [LEN_W-1:0]   cnt;
`ifdef HF_LEN_PREFIX_EN
  logic [LEN_W-1:0]   pfx_q;
  logic [LEN_W-1:0]   len_q;
`endif

  // The lookup reads the pre-edge table contents, so a write in the same cycle is not seen yet.
  logic [MAX_LEN-1:0] lk_code;
  logic [LEN_W-1:0]   lk_len;
  logic               lk_bad;
  assign lk_code = tbl_code_q[sym_q];
  assign lk_len  = tbl_len_q[sym_q];
  assign lk_bad  = en_q && ((lk_len == '0) || (lk_len > MAX_LEN_L));

  // Code table: a flop array. Reset clears it, and it can be written in any state.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < TBL_N; i++) begin
        tbl_code_q[i] <= '0;
        tbl_len_q[i]  <= '0;
      end
    end else if (tbl_we) begin
      tbl_code_q[tbl_addr] <= tbl_code;
      tbl_len_q[tbl_addr]  <= tbl_len;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and serial outputs. Outputs are decoded from state, so they are 0 outside bit cycles.
  always_comb begin
    state_d   = state_q;
    sym_ready = 1'b0;
    hf_out    = 1'b0;
    hf_valid  = 1'b0;
    hf_last   = 1'b0;
    case (state_q)
      IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (lk_bad)
          state_d = IDLE;
`ifdef HF_LEN_PREFIX_EN
        else if (en_q)
          state_d = PREFIX;
`endif
        else
          state_d = SHIFT;
      end
`ifdef HF_LEN_PREFIX_EN
      PREFIX: begin
        hf_valid = 1'b1;
        hf_out   = pfx_q[LEN_W-1];
        if (cnt == ONE_L) state_d = SHIFT;
      end
`endif
      SHIFT: begin
        hf_valid = 1'b1;
        hf_out   = shreg[MAX_LEN-1];
        hf_last  = (cnt == ONE_L);
        if (cnt == ONE_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Datapath: latch the symbol and mode, load a left-justified code, then shift one bit per cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sym_q    <= '0;
      en_q     <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      code_err <= 1'b0;
`ifdef HF_LEN_PREFIX_EN
      pfx_q    <= '0;
      len_q    <= '0;
`endif
    end else begin
      code_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sym_valid) begin
            sym_q <= sym_in;
            en_q  <= EN;
          end
        end
        LOOKUP: begin
          if (lk_bad) begin
            code_err <= 1'b1;
          end else if (en_q) begin
            // Code bits above len are shifted off the top, so only the low len bits are sent.
            shreg <= lk_code << (MAX_LEN_L - lk_len);
`ifdef HF_LEN_PREFIX_EN
            pfx_q <= lk_len;
            len_q <= lk_len;
            cnt   <= LEN_W'(LEN_W);
`else
            cnt   <= lk_len;
`endif
          end else begin
            shreg <= MAX_LEN'(sym_q) << BYP_SH;
            cnt   <= LEN_W'(SYM_W);
          end
        end
`ifdef HF_LEN_PREFIX_EN
        PREFIX: begin
          pfx_q <= pfx_q << 1;
          cnt   <= (cnt == ONE_L) ? len_q : cnt - 1'b1;
        end
`endif
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hf_compression_table.sv
// Self-checking bench for hf_compression_table.
// A behavioural model turns every accepted symbol into its per-cycle output
// stream. Those outputs are compared on every falling edge. Literal expectations
// on the captured bit streams pin both the model and the DUT.
module tb_hf_compression_table;

`ifdef HF_LEN_PREFIX_EN
  localparam int PFX = 1;
`else
  localparam int PFX = 0;
`endif

  bit          CLK;
  logic        Reset, EN, sym_valid, sym_ready, tbl_we;
  logic [3:0]  sym_in, tbl_addr;
  logic [15:0] tbl_code;
  logic [5:0]  tbl_len;
  logic        hf_out, hf_valid, hf_last, code_err, busy;

  hf_compression_table #(.SYM_W(4), .MAX_LEN(16), .LEN_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .EN(EN), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code),
    .tbl_len(tbl_len), .hf_out(hf_out), .hf_valid(hf_valid), .hf_last(hf_last),
    .code_err(code_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // model state: table image and expected {busy,valid,out,last,err} per cycle
  logic [15:0] mcode [16];
  logic [5:0]  mlen  [16];
  logic [4:0]  q [$];

  int checks = 0, failures = 0;

  // requests from the stimulus process to the compare process
  int          acc_req = 0, acc_seen = 0;
  logic [3:0]  acc_sym;
  logic        acc_en;
  int          lit_req = 0, lit_seen = 0;
  string       lit_name;
  logic [63:0] lit_act, lit_exp;

  // captured output stream
  logic [63:0] cap = '0;
  int          cap_n = 0, last_n = 0, last_at = 0, err_n = 0;

  // table image follows the DUT write rule: visible from the edge after the strobe
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin mcode[i] = '0; mlen[i] = '0; end
    end else if (tbl_we) begin
      mcode[tbl_addr] = tbl_code;
      mlen[tbl_addr]  = tbl_len;
    end
  end

  function automatic void model_push(logic [3:0] s, logic e);
    logic [15:0] c;
    logic [5:0]  l;
    q.push_back(5'b10000);  // lookup cycle
    if (!e) begin
      for (int i = 0; i < 4; i++) q.push_back({1'b1, 1'b1, s[3-i], (i == 3), 1'b0});
    end else begin
      c = mcode[s];
      l = mlen[s];
      if (l == 0 || l > 16) q.push_back(5'b00001);
      else begin
        if (PFX != 0)
          for (int i = 0; i < 6; i++) q.push_back({1'b1, 1'b1, l[5-i], 1'b0, 1'b0});
        for (int i = 0; i < int'(l); i++)
          q.push_back({1'b1, 1'b1, c[int'(l)-1-i], (i == int'(l)-1), 1'b0});
      end
    end
  endfunction

  // compare process: literal requests, then the per-cycle model check
  always @(negedge CLK) begin : cmp
    logic [4:0] e, a;
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      checks++;
      if (lit_act !== lit_exp) begin
        failures++;
        $display("FAIL %s: got %0h want %0h", lit_name, lit_act, lit_exp);
      end
    end
    if (!Reset) q.delete();
    else if (acc_req != acc_seen) begin
      acc_seen = acc_req;
      model_push(acc_sym, acc_en);
    end
    e = (Reset && q.size() != 0) ? q.pop_front() : 5'b0;
    a = {busy, hf_valid, hf_out, hf_last, code_err};
    checks++;
    if (a !== e || sym_ready !== ~e[4]) begin
      failures++;
      $display("FAIL cycle@%0t: {busy,vld,out,last,err,rdy} got %b%b want %b%b",
               $time, a, sym_ready, e, ~e[4]);
    end
  end

  // capture of the emitted bits, final-bit markers and error pulses
  always @(negedge CLK) begin
    if (Reset) begin
      if (hf_valid) begin
        cap = {cap[62:0], hf_out};
        cap_n++;
        if (hf_last) begin last_n++; last_at = cap_n; end
      end
      if (code_err) err_n++;
    end
  end

  task automatic lit(input string n, input logic [63:0] a, input logic [63:0] e);
    lit_name = n; lit_act = a; lit_exp = e; lit_req++;
    @(negedge CLK); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] c, input logic [5:0] l);
    @(negedge CLK); #1;
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
    @(negedge CLK); #1;
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input logic e);
    int n;
    n = 0;
    @(negedge CLK); #1;
    sym_in = s; EN = e; sym_valid = 1'b1;
    while (!sym_ready && n < 200) begin @(negedge CLK); #1; n++; end
    if (!sym_ready) begin
      sym_valid = 1'b0;
      lit("send_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge CLK); #1;
      acc_sym = s; acc_en = e; acc_req++;
      sym_valid = 1'b0;
      EN = ~e;  // a mid-symbol mode change must not matter
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge CLK); #1; n++; end
    while (!(q.size() == 0 && sym_ready && acc_req == acc_seen) && n < 300);
    if (n >= 300) lit("idle_timeout", 64'd0, 64'd1);
  endtask

  // checks one symbol's bits, length, single hf_last on the final bit and error count
  task automatic chk_sym(input string n, input int b_n, input int b_l, input int b_e,
                         input int en, input logic [63:0] ebits, input int eerr);
    logic [63:0] m;
    int d;
    d = cap_n - b_n;
    m = (d >= 64) ? '1 : ((64'd1 << d) - 1);
    lit({n, "_len"}, 64'(d), 64'(en));
    lit({n, "_bits"}, cap & m, ebits);
    lit({n, "_err"}, 64'(err_n - b_e), 64'(eerr));
    if (en > 0) lit({n, "_last"}, {32'(last_n - b_l), 32'(last_at)}, {32'd1, 32'(cap_n)});
  endtask

  int bn, bl, be;
  logic [3:0] rs;

  initial begin
    Reset = 1'b0; EN = 1'b1; sym_valid = 1'b0; sym_in = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
    repeat (3) @(negedge CLK);
    #1;
    lit("reset_state", {58'd0, busy, hf_valid, hf_out, hf_last, code_err, sym_ready}, 64'b000001);
    @(negedge CLK); Reset = 1'b1;

    // compress: junk above len must be ignored
    wr(4'd3, 16'hFFF5, 6'd3);
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd3, 1'b1); wait_idle();
    chk_sym("t1", bn, bl, be, 3 + 6*PFX, (PFX != 0) ? 64'h1D : 64'h5, 0);

    // raw bypass of A
    bn = cap_n; bl = last_n; be = err_n;
    send(4'hA, 1'b0); wait_idle();
    chk_sym("bypass", bn, bl, be, 4, 64'hA, 0);

    // len 0 entry
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd5, 1'b1); wait_idle();
    chk_sym("len0", bn, bl, be, 0, 64'h0, 1);

    // len above MAX_LEN
    wr(4'd6, 16'h1234, 6'd17);
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd6, 1'b1); wait_idle();
    chk_sym("len17", bn, bl, be, 0, 64'h0, 1);

    // boundary lengths, sent back to back
    wr(4'd7, 16'hA5C3, 6'd16);
    wr(4'd1, 16'h0001, 6'd1);
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd7, 1'b1); wait_idle();
    chk_sym("len16", bn, bl, be, 16 + 6*PFX, (PFX != 0) ? 64'h10A5C3 : 64'hA5C3, 0);
    send(4'd1, 1'b1); send(4'd3, 1'b1); send(4'hC, 1'b0); wait_idle();

    // table write during SHIFT does not disturb the symbol in flight
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd3, 1'b1);
    @(negedge CLK);
    wr(4'd3, 16'h0003, 6'd2);
    wait_idle();
    chk_sym("wr_shift_old", bn, bl, be, 3 + 6*PFX, (PFX != 0) ? 64'h1D : 64'h5, 0);
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd3, 1'b1); wait_idle();
    chk_sym("wr_shift_new", bn, bl, be, 2 + 6*PFX, (PFX != 0) ? 64'hB : 64'h3, 0);

    // reset during the second code bit
    wr(4'd3, 16'h0005, 6'd3);
    send(4'd3, 1'b1);
    repeat (3 + 6*PFX) @(negedge CLK);
    #1 Reset = 1'b0;
    #1 rs = {hf_valid, busy, hf_out, sym_ready};
    lit("rst_abort", 64'(rs), 64'b0001);
    @(negedge CLK); Reset = 1'b1;
    bn = cap_n; bl = last_n; be = err_n;
    send(4'd3, 1'b1); wait_idle();
    chk_sym("tbl_cleared", bn, bl, be, 0, 64'h0, 1);

    @(negedge CLK); #1;
    lit("end_idle", {62'd0, busy, sym_ready}, 64'b01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
